fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core, replacing the direct pc → instruction-memory path. It generates sequential fetch addresses and issues them to instruction memory over a request/grant handshake. In-order responses are buffered with their PC in a prefetch queue. Instructions are presented to decode over valid/ready, and a redirect from branch resolution flushes the stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 4, queue entries and maximum in-flight requests. Power of two, ≥2.

Ports:
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  new fetch address; word aligned.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (fetch_pc).
- imem_gnt  in  1  request accepted when imem_req & imem_gnt.
- imem_rvalid  in  1  response valid; in order, ≥1 cycle after grant; no backpressure.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  queue head valid to decode.
- inst_data  out  32  head instruction.
- inst_pc  out  32  head PC.
- inst_ready  in  1  decode accepts head when inst_valid & inst_ready.

## Operation
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of next expected response.
  - outstanding: granted requests without a response, width $clog2(QDEPTH)+1.
  - drop: responses still to discard, same width.
  - queue: count plus entries {pc, instr}.
- Request:
  - imem_req = (outstanding + count < QDEPTH) & !redirect_valid.
  - imem_addr = fetch_pc.
  - On grant: fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC → 0) and outstanding++.
  - imem_req may deassert before grant only in a redirect cycle.
- Response (imem_rvalid):
  - outstanding-- in all cases.
  - If drop>0 or redirect_valid: discard the word; drop-- only if drop>0.
  - Otherwise: push {resp_pc, imem_rdata}, then resp_pc += 4.
  - Credit rule guarantees the queue never overflows. A push into a full queue is an assertion failure.
- Pop: inst_valid = count≠0. Handshake removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect, which has priority over all other events in the cycle:
  - fetch_pc ← redirect_pc and resp_pc ← redirect_pc.
  - count ← 0.
  - drop ← outstanding − imem_rvalid.
  - No grant is possible in that cycle.
  - A head popped in the redirect cycle counts as delivered; squashing it is decode's job.
- inst_data/inst_pc are 0 when the queue is empty.

## Timing
- Reset (asserted low, asynchronous):
  - fetch_pc = resp_pc = RESET_PC.
  - outstanding = drop = count = 0.
  - inst_valid = 0, inst_data = 0, inst_pc = 0.
  - imem_req = 0 while reset is low; imem_addr = RESET_PC.
- First cycle after reset release: imem_req = 1, imem_addr = RESET_PC.
- Latency: a response in cycle N is visible at the queue head in N+1. There is no combinational bypass.
- Steady state with gnt held 1 and 1-cycle memory: one instruction per cycle to decode. First instruction appears 2 cycles after the first grant.
- Redirect in cycle N:
  - Cycle N+1: inst_valid = 0 and imem_req = 1 at redirect_pc (credit permitting).
  - First redirected instruction appears ≥2 cycles after its grant, plus any drop drain.
- Reset mid-burst: all in-flight responses are lost. Memory must also be reset by the same reset.
- Back-to-back redirects: the second overwrites the first. drop is recomputed from the current outstanding count.

## Structure
- Package fetch_pkg holds:
  - XLEN=32.
  - Default RESET_PC constant.
  - Typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t.
  - Parameter QDEPTH.
  - Ports: push, pop, flush, count, head, full, empty.
  - Pointers wrap modulo QDEPTH; flush has priority over push and pop.
- fetch_unit holds the PC registers, credit counters, drop logic and handshake glue.

## Test plan
- Reset, gnt=1, 1-cycle memory returning addr|32'hA000_0000, inst_ready=1:
  - decode sees pc 0,4,8,… one per cycle.
  - First inst_valid 2 cycles after reset release.
- inst_ready=0 for 10 cycles:
  - imem_req drops after 4 grants; queue holds pc 0..12.
  - On release, drains in order with no loss or duplication.
- 3-cycle memory latency, 3 requests in flight, redirect_pc=32'h100:
  - 3 stale responses discarded.
  - Next inst_pc = 32'h100.
- Redirect coinciding with imem_rvalid and an inst_ready pop:
  - That response is dropped; the pop counts as delivered.
  - drop = outstanding−1.
  - Next instruction delivered is from 32'h100.
- fetch_pc = 32'hFFFF_FFF8:
  - Requests go FFFF_FFF8, FFFF_FFFC, 0000_0000; inst_pc follows the same sequence.
- reset pulsed low mid-stream with 2 outstanding:
  - All outputs return to reset values immediately.
  - Refetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN             : architectural register / address width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : one buffered fetch result {pc, instr}
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding fetched instructions with their PCs.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wdata_i at the tail (ignored when full)
//   wdata_i    : entry to write
//   pop_i      : remove the head (ignored when empty)
//   flush_i    : empty the queue; wins over push and pop
//   count_o    : number of valid entries (0..QDEPTH)
//   head_o     : head entry, all zeros when empty
//   full_o     : count_o == QDEPTH
//   empty_o    : count_o == 0
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  fetch_entry_t               wdata_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [$clog2(QDEPTH):0]    count_o,
   output fetch_entry_t               head_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t    mem_q [QDEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (count_q == CW'(QDEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointers are PW bits wide, so power-of-two depth wraps them for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential fetch addresses over a
// req/gnt handshake, buffers in-order responses with their PC and hands
// them to decode over valid/ready. A redirect flushes the stage.
//   clk, reset       : clock, asynchronous active-low reset
//   redirect_valid/pc: taken branch/jump and its target
//   imem_req/addr/gnt: fetch request handshake
//   imem_rvalid/rdata: in-order instruction responses, no backpressure
//   inst_valid/data/pc/ready : queue head towards decode
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              QDEPTH   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic [CW-1:0]   q_count;
   fetch_entry_t    q_head;
   fetch_entry_t    q_wdata;
   logic            q_full;
   logic            q_empty;
   logic            q_push;
   logic            q_pop;
   logic [CW:0]     credit_used;
   logic            grant;

   // Every in-flight request owns a queue slot, so responses never overflow.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, q_count};
   assign imem_req    = reset & (credit_used < (CW+1)'(QDEPTH)) & ~redirect_valid;
   assign imem_addr   = fetch_pc_q;
   assign grant       = imem_req & imem_gnt;

   assign q_push  = imem_rvalid & ~redirect_valid & (drop_q == '0);
   assign q_pop   = inst_valid & inst_ready;
   assign q_wdata = '{pc: resp_pc_q, instr: imem_rdata};

   assign inst_valid = ~q_empty;
   assign inst_data  = q_head.instr;
   assign inst_pc    = q_head.pc;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_d        = drop_q;
      outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         drop_d     = outstanding_q - CW'(imem_rvalid);
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (imem_rvalid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               resp_pc_d = resp_pc_q + XLEN'(4);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (q_push),
      .wdata_i (q_wdata),
      .pop_i   (q_pop),
      .flush_i (redirect_valid),
      .count_o (q_count),
      .head_o  (q_head),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   a_no_overflow : assert property (@(posedge clk) disable iff (!reset) !(q_push && q_full));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mem_req_t;

   typedef struct {
      logic        ready;
      logic        exp_req;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   mem_req_t     pend[$];
   fetch_entry_t sb[$];

   int unsigned cyc = 0;
   int unsigned lat = 1;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_deliv = 0;
   logic        ready_r, gnt_r, redir_v;
   logic [31:0] redir_pc_r;
   logic [31:0] nf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic timeout(input string name);
      n_chk++;
      $display("FAIL %s: condition not reached within budget (cycle %0d)", name, cyc);
   endtask

   // Called at a falling edge: apply inputs for this cycle, memory model included.
   task automatic drive();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = pend[0].addr | 32'hA000_0000;
      end
      inst_ready     = ready_r;
      imem_gnt       = gnt_r;
      redirect_valid = redir_v;
      redirect_pc    = redir_pc_r;
      #1;
   endtask

   // Scoreboard + memory bookkeeping for the cycle, then move to the next falling edge.
   task automatic advance();
      fetch_entry_t e;
      mem_req_t     m;
      if (inst_valid && inst_ready) begin
         n_deliv++;
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_inst: got pc %h, nothing expected (cycle %0d)", inst_pc, cyc);
         end else begin
            e = sb.pop_front();
            chk("sb_inst_pc", inst_pc, e.pc);
            chk("sb_inst_data", inst_data, e.instr);
         end
      end
      if (imem_rvalid) pend.delete(0);
      if (redirect_valid) begin
         sb.delete();
         nf = redirect_pc;
      end
      if (imem_req && imem_gnt) begin
         chk("fetch_addr", imem_addr, nf);
         e.pc    = nf;
         e.instr = nf | 32'hA000_0000;
         sb.push_back(e);
         m.addr = nf;
         m.due  = cyc + lat;
         pend.push_back(m);
         nf = nf + 32'd4;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[13];
      bit   hit;

      // Stall scenario from reset: 1-cycle memory, decode stalled for 10 cycles.
      tbl = '{
         '{1'b0, 1'b1, 1'b0, 32'h0},
         '{1'b0, 1'b1, 1'b0, 32'h0},
         '{1'b0, 1'b1, 1'b1, 32'h0},
         '{1'b0, 1'b1, 1'b1, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h0},
         '{1'b0, 1'b0, 1'b1, 32'h0},
         '{1'b1, 1'b0, 1'b1, 32'h0},
         '{1'b1, 1'b1, 1'b1, 32'h4},
         '{1'b1, 1'b1, 1'b1, 32'h8}
      };

      reset = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
      ready_r = 1'b0; gnt_r = 1'b1; redir_v = 1'b0; redir_pc_r = '0;
      nf = RST_PC;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_data", inst_data, 32'd0);
      chk("rst_pc", inst_pc, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         ready_r = tbl[i].ready;
         drive();
         chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
         chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].exp_pc);
         chk($sformatf("tbl%0d_data", i), inst_data,
             tbl[i].exp_valid ? (tbl[i].exp_pc | 32'hA000_0000) : 32'd0);
         advance();
      end

      // Steady state: one instruction per cycle.
      n_deliv = 0;
      repeat (20) begin drive(); advance(); end
      chk("steady_rate", n_deliv, 20);

      // 3-cycle memory, redirect with 3 requests in flight.
      lat = 3;
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         if (pend.size() == 3) hit = 1;
         else begin drive(); advance(); end
      end
      if (!hit) timeout("wait_3_inflight");
      redir_v = 1'b1; redir_pc_r = 32'h100;
      drive();
      redir_v = 1'b0;
      advance();
      drive();
      chk("redir3_n1_valid", 32'(inst_valid), 32'd0);
      chk("redir3_n1_req", 32'(imem_req), 32'd1);
      chk("redir3_n1_addr", imem_addr, 32'h100);
      advance();
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         drive();
         if (inst_valid) begin
            hit = 1;
            chk("redir3_first_pc", inst_pc, 32'h100);
         end
         advance();
      end
      if (!hit) timeout("redir3_first_inst");

      // 1-cycle memory, redirect coinciding with a response and a pop.
      lat = 1;
      repeat (8) begin drive(); advance(); end
      hit = 0;
      for (int i = 0; i < 30 && !hit; i++) begin
         drive();
         if (imem_rvalid && inst_valid) begin
            hit = 1;
            redirect_valid = 1'b1;
            redirect_pc    = 32'h100;
            #1;
         end
         advance();
      end
      if (!hit) timeout("wait_rvalid_pop");
      drive();
      chk("coinc_n1_valid", 32'(inst_valid), 32'd0);
      chk("coinc_n1_addr", imem_addr, 32'h100);
      advance();
      drive();
      chk("coinc_n2_valid", 32'(inst_valid), 32'd0);
      advance();
      drive();
      chk("coinc_n3_valid", 32'(inst_valid), 32'd1);
      chk("coinc_n3_pc", inst_pc, 32'h100);
      advance();

      // Address wrap at the top of the address space.
      redir_v = 1'b1; redir_pc_r = 32'hFFFF_FFF8;
      drive();
      redir_v = 1'b0;
      advance();
      drive(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8); chk("wrap_req0", 32'(imem_req), 32'd1); advance();
      drive(); chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC); advance();
      drive(); chk("wrap_addr2", imem_addr, 32'h0000_0000); chk("wrap_pc0", inst_pc, 32'hFFFF_FFF8); advance();
      drive(); chk("wrap_pc1", inst_pc, 32'hFFFF_FFFC); advance();
      drive(); chk("wrap_pc2", inst_pc, 32'h0000_0000); advance();

      // Reset pulse mid-stream with 2 outstanding.
      lat = 3;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (pend.size() == 2) hit = 1;
         else begin drive(); advance(); end
      end
      if (!hit) timeout("wait_2_inflight");
      reset = 1'b0;
      imem_rvalid = 1'b0;
      #1;
      chk("midrst_req", 32'(imem_req), 32'd0);
      chk("midrst_addr", imem_addr, RST_PC);
      chk("midrst_valid", 32'(inst_valid), 32'd0);
      chk("midrst_data", inst_data, 32'd0);
      chk("midrst_pc", inst_pc, 32'd0);
      pend.delete();
      sb.delete();
      nf = RST_PC;
      @(negedge clk);
      reset = 1'b1;
      drive();
      chk("postrst_req", 32'(imem_req), 32'd1);
      chk("postrst_addr", imem_addr, RST_PC);
      advance();
      hit = 0;
      for (int i = 0; i < 15 && !hit; i++) begin
         drive();
         if (inst_valid) begin
            hit = 1;
            chk("postrst_first_pc", inst_pc, RST_PC);
         end
         advance();
      end
      if (!hit) timeout("postrst_first_inst");
      repeat (6) begin drive(); advance(); end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
